xnor_popcount_acc: RTL

- Consumer end of the 8-bit XNOR match datapath in the binarized MAC.
- Takes a stream of 8-bit match vectors (bit=1 means the operand bits agreed) through a valid/ready handshake.
- Counts the set bits in each beat and accumulates them over BEATS beats.
- Returns the total match count and the signed ±1 dot product through a second valid/ready handshake.

---
 rtl/xnor_popcount_acc_pkg.sv | 17 +
 rtl/xnor_popcount_acc_eight_bit_popcount.sv | 42 ++++
 rtl/xnor_popcount_acc.sv | 86 ++++++++
 3 files changed

// File: rtl/xnor_popcount_acc_pkg.sv
// Shared definitions for the XNOR match popcount accumulator.
package xnor_popcount_acc_pkg;

    localparam int MATCH_W = 8;
    localparam int POP8_W  = 4;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Width needed to hold a match total of 0..MATCH_W*beats.
    function automatic int pop_width(input int beats);
        return $clog2(MATCH_W * beats + 1);
    endfunction

endpackage

// File: rtl/xnor_popcount_acc_eight_bit_popcount.sv
// Structural 8-bit popcount: a carry-save tree of half and full adders.
module popcount_ha (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic co
);
    assign sum = a ^ b;
    assign co  = a & b;
endmodule

module popcount_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));
endmodule

module eight_bit_popcount (
    input  logic [7:0] i_bits,
    output logic [3:0] o_count
);
    logic w_s0, w_s1, w_s2, w_c0, w_c1, w_c2;
    logic w_k0, w_t, w_u, w_v;

    // Level 1: compress eight weight-1 bits into three sums and three carries.
    popcount_fa u_fa0 (.a(i_bits[0]), .b(i_bits[1]), .ci(i_bits[2]), .sum(w_s0), .co(w_c0));
    popcount_fa u_fa1 (.a(i_bits[3]), .b(i_bits[4]), .ci(i_bits[5]), .sum(w_s1), .co(w_c1));
    popcount_ha u_ha0 (.a(i_bits[6]), .b(i_bits[7]), .sum(w_s2), .co(w_c2));

    popcount_fa u_fa2 (.a(w_s0), .b(w_s1), .ci(w_s2), .sum(o_count[0]), .co(w_k0));

    // Four weight-2 bits reduce to one weight-2 bit and two weight-4 bits.
    popcount_fa u_fa3 (.a(w_c0), .b(w_c1), .ci(w_c2), .sum(w_t), .co(w_u));
    popcount_ha u_ha1 (.a(w_t), .b(w_k0), .sum(o_count[1]), .co(w_v));

    popcount_ha u_ha2 (.a(w_u), .b(w_v), .sum(o_count[2]), .co(o_count[3]));
endmodule

// File: rtl/xnor_popcount_acc.sv
// Accumulates per-beat XNOR match counts over BEATS beats and returns the
// total plus the signed +/-1 dot product through a valid/ready handshake.
module xnor_popcount_acc
    import xnor_popcount_acc_pkg::*;
#(
    parameter  int BEATS = 4,
    localparam int POP_W = pop_width(BEATS),
    localparam int OUT_W = POP_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MATCH_W-1:0] in_match,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [POP_W-1:0]   out_pop,
    output logic [OUT_W-1:0]   out_dot
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t             r_state, w_state_nxt;
    logic [POP_W-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [POP_W-1:0]   r_out_pop, w_out_pop_nxt;
    logic [OUT_W-1:0]   r_out_dot, w_out_dot_nxt;

    logic [POP8_W-1:0]  w_pop8;
    logic [POP_W-1:0]   w_sum;
    logic               w_in_xfer, w_out_xfer, w_last;

    eight_bit_popcount u_pop (
        .i_bits  (in_match),
        .o_count (w_pop8)
    );

    assign out_valid  = (r_state == HOLD);
    assign in_ready   = (r_state == ACC) ? 1'b1 : out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_last     = (r_beat_cnt == CNT_W'(BEATS - 1));
    assign w_sum      = r_acc + POP_W'(w_pop8);
    assign out_pop    = r_out_pop;
    assign out_dot    = r_out_dot;

    // acc and beat_cnt are always zero in HOLD, so an input beat accepted
    // alongside an output transfer follows the same path as one taken in ACC.
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_beat_cnt_nxt = r_beat_cnt;
        w_out_pop_nxt  = r_out_pop;
        w_out_dot_nxt  = r_out_dot;
        if (w_out_xfer)
            w_state_nxt = ACC;
        if (w_in_xfer) begin
            if (w_last) begin
                w_out_pop_nxt  = w_sum;
                w_out_dot_nxt  = (OUT_W'(w_sum) << 1) - OUT_W'(MATCH_W * BEATS);
                w_acc_nxt      = '0;
                w_beat_cnt_nxt = '0;
                w_state_nxt    = HOLD;
            end else begin
                w_acc_nxt      = w_sum;
                w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ACC;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_out_pop  <= '0;
            r_out_dot  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_out_pop  <= w_out_pop_nxt;
            r_out_dot  <= w_out_dot_nxt;
        end
    end

endmodule
